snake_screen_ctrl: RTL and testbench
====================================

# snake_screen_ctrl

Top-level screen sequencer for the Snake game, with a parametrised screen size. It steps through title, play, pause and game-over screens, and runs a full-frame black clear before play and before game-over. While clearing, it drives a raster-scan pixel address to the VGA framebuffer. It also tells the game logic when to initialise and when to run.

## Interface

Parameters:
- H_RES, 160, horizontal pixels cleared per line
- V_RES, 120, lines cleared per frame
- XW, 8, width of clr_x; must satisfy 2^XW >= H_RES
- YW, 7, width of clr_y; must satisfy 2^YW >= V_RES

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start_n  in  1  start/quit button, active-low, already synchronous to clk
- pause_n  in  1  pause button, active-low, already synchronous to clk
- is_dead  in  1  level from game logic: snake has died
- show_title  out  1  framebuffer source = title image
- show_pause  out  1  overlay pause banner
- show_game_over  out  1  framebuffer source = game-over image
- draw_black  out  1  write black at (clr_x, clr_y) this cycle
- clr_x  out  XW  clear scan column
- clr_y  out  YW  clear scan row
- game_init  out  1  one-cycle pulse: reset snake/food state
- game_en  out  1  game logic may advance

## Operation

- Press detection:
  - A press is a falling edge of a button: previous sample 1, current sample 0.
  - Previous-sample registers reset to 1.
  - A held button yields exactly one press.
- States: TITLE, CLEAR, PLAY, PAUSE, OVER. A dest register holds PLAY or OVER for CLEAR.
- TITLE: start press -> CLEAR, dest=PLAY.
- CLEAR:
  - draw_black=1 every cycle.
  - clr_x increments each cycle; at H_RES-1 it wraps to 0 and clr_y increments.
  - At (H_RES-1, V_RES-1): go to dest, and clr_x and clr_y return to 0.
  - Button presses and is_dead are ignored.
- PLAY:
  - is_dead=1 -> CLEAR, dest=OVER. This takes priority over a simultaneous pause press.
  - Otherwise, pause press -> PAUSE.
- PAUSE:
  - start press -> TITLE (quit). This takes priority over a simultaneous pause press.
  - Otherwise, pause press -> PLAY, with no game_init.
  - is_dead is ignored.
- OVER: start press -> TITLE.
- Screen outputs (Moore, decoded from the state register only):
  - show_title=1 in TITLE.
  - show_pause=1 in PAUSE.
  - show_game_over=1 in OVER.
  - draw_black=1 in CLEAR.
  - Every output not listed for a state is 0.
- game_init:
  - Set to 1 on the first PLAY cycle that follows CLEAR, for exactly one cycle.
  - Stays 0 when PLAY is entered from PAUSE.
- game_en: 1 in PLAY except during the game_init cycle.
- Reset, including mid-clear or mid-play:
  - state=TITLE, dest=PLAY, clr_x=0, clr_y=0.
  - Outputs: show_title=1, all other outputs 0.

## Timing

- A press sampled at edge n changes the state at edge n+1. Outputs follow combinationally from the state, with no further latency.
- CLEAR lasts exactly H_RES*V_RES cycles: 19200 at the defaults.
  - Pixel k=0..H_RES*V_RES-1 is presented at CLEAR cycle k, with x = k mod H_RES and y = k div H_RES.
- game_init lands in the cycle immediately after the last draw_black cycle.
- clr_x/clr_y hold at 0 outside CLEAR. Counter arithmetic is unsigned, at widths XW/YW.

## Structure

- Shared package snake_pkg holds:
  - the state enumeration,
  - default H_RES/V_RES,
  - the colour constant BLACK used by the framebuffer writer.
- Sub-module btn_press: 1-bit falling-edge detector, instantiated twice (start, pause).
- Everything else is one always-block for state/dest/counters plus a combinational output decode.

## Test plan

- Reset, then hold start_n=1 for 10 cycles -> show_title=1, all other outputs 0, clr_x=clr_y=0.
- Single start press -> draw_black=1 for exactly 19200 cycles, with (clr_x, clr_y) running (0,0), (1,0) … (159,0), (0,1) … (159,119). Then game_init=1 for one cycle, then game_en=1.
- In PLAY, pause press -> show_pause=1 and game_en=0. Second pause press -> PLAY with game_en=1 and game_init never pulsing.
- In PLAY, is_dead=1 together with a pause press -> CLEAR (dest OVER) for 19200 cycles, then show_game_over=1. A start press then -> show_title=1.
- Hold start_n=0 for 50 cycles in TITLE -> exactly one transition to CLEAR. Start presses during CLEAR are ignored.
- Assert rst at clear pixel (80,60) -> immediate TITLE, clr_x=clr_y=0. After release, a start press restarts the clear from (0,0).

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake screen sequencer
package snake_pkg;

  // Screen sequencer states; CLEAR is shared by the pre-play and pre-game-over wipes
  typedef enum logic [2:0] {
    ST_TITLE = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } scr_state_t;

  localparam int DEF_H_RES = 160;
  localparam int DEF_V_RES = 120;

  // Colour written by the framebuffer writer while draw_black is high
  localparam logic [7:0] BLACK = 8'h00;

endpackage

// File: rtl/btn_press.sv
// rtl/btn_press.sv - falling-edge press detector for an active-low button
module btn_press (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic prev;

  // Remember the last sample and register a one-cycle pulse on each 1->0 step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= 1'b1;
      press <= 1'b0;
    end else begin
      prev  <= btn_n;
      press <= prev & ~btn_n;
    end
  end

endmodule

// File: rtl/snake_screen_ctrl.sv
// rtl/snake_screen_ctrl.sv - title/play/pause/over sequencer with full-frame clear
module snake_screen_ctrl
  import snake_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES,
  parameter int XW    = 8,
  parameter int YW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_n,
  input  logic          pause_n,
  input  logic          is_dead,
  output logic          show_title,
  output logic          show_pause,
  output logic          show_game_over,
  output logic          draw_black,
  output logic [XW-1:0] clr_x,
  output logic [YW-1:0] clr_y,
  output logic          game_init,
  output logic          game_en
);

  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  scr_state_t    state, state_nx;
  scr_state_t    dest, dest_nx;
  logic [XW-1:0] x_nx;
  logic [YW-1:0] y_nx;
  logic          from_clear;
  logic          start_press;
  logic          pause_press;

  btn_press u_start (
    .clk   (clk),
    .rst   (rst),
    .btn_n (start_n),
    .press (start_press)
  );

  btn_press u_pause (
    .clk   (clk),
    .rst   (rst),
    .btn_n (pause_n),
    .press (pause_press)
  );

  // State, clear destination and raster counters; from_clear marks the first cycle after a wipe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_TITLE;
      dest       <= ST_PLAY;
      clr_x      <= '0;
      clr_y      <= '0;
      from_clear <= 1'b0;
    end else begin
      state      <= state_nx;
      dest       <= dest_nx;
      clr_x      <= x_nx;
      clr_y      <= y_nx;
      from_clear <= (state == ST_CLEAR);
    end
  end

  // Next-state logic; counters only move in CLEAR and return to zero as it ends
  always_comb begin
    state_nx = state;
    dest_nx  = dest;
    x_nx     = clr_x;
    y_nx     = clr_y;
    unique case (state)
      ST_TITLE: begin
        if (start_press) begin
          state_nx = ST_CLEAR;
          dest_nx  = ST_PLAY;
        end
      end
      ST_CLEAR: begin
        if (clr_x == X_LAST) begin
          x_nx = '0;
          if (clr_y == Y_LAST) begin
            y_nx     = '0;
            state_nx = dest;
          end else begin
            y_nx = clr_y + YW'(1);
          end
        end else begin
          x_nx = clr_x + XW'(1);
        end
      end
      ST_PLAY: begin
        if (is_dead) begin
          state_nx = ST_CLEAR;
          dest_nx  = ST_OVER;
        end else if (pause_press) begin
          state_nx = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (start_press) begin
          state_nx = ST_TITLE;
        end else if (pause_press) begin
          state_nx = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (start_press) begin
          state_nx = ST_TITLE;
        end
      end
      default: state_nx = ST_TITLE;
    endcase
  end

  // Screen selects decoded from state alone; game_init only on PLAY entry out of CLEAR
  always_comb begin
    show_title     = (state == ST_TITLE);
    show_pause     = (state == ST_PAUSE);
    show_game_over = (state == ST_OVER);
    draw_black     = (state == ST_CLEAR);
    game_init      = (state == ST_PLAY) && from_clear;
    game_en        = (state == ST_PLAY) && !from_clear;
  end

endmodule

// File: tb/tb_snake_screen_ctrl.sv
// tb/tb_snake_screen_ctrl.sv - scoreboard bench for snake_screen_ctrl
module tb_snake_screen_ctrl;

  localparam int H    = 160;
  localparam int V    = 120;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int NPIX = H * V;

  localparam int M_TITLE = 0;
  localparam int M_CLEAR = 1;
  localparam int M_PLAY  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_OVER  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_n = 1'b1;
  logic          pause_n = 1'b1;
  logic          is_dead = 1'b0;
  logic          show_title, show_pause, show_game_over, draw_black;
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic          game_init, game_en;

  typedef struct {
    int            cyc;
    logic [5:0]    flags;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  logic [5:0] mon_got;

  int cnt = 0;
  int checks = 0;
  int errors = 0;

  // Reference model: screen as an int, clear progress as a flat pixel index
  int   m_st, m_dest, m_k;
  bit   m_init;
  logic m_prev_s, m_press_s, m_prev_p, m_press_p;

  snake_screen_ctrl #(.H_RES(H), .V_RES(V), .XW(XW), .YW(YW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_n        (start_n),
    .pause_n        (pause_n),
    .is_dead        (is_dead),
    .show_title     (show_title),
    .show_pause     (show_pause),
    .show_game_over (show_game_over),
    .draw_black     (draw_black),
    .clr_x          (clr_x),
    .clr_y          (clr_y),
    .game_init      (game_init),
    .game_en        (game_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached at cycle %0d", cnt);
    $fatal(1);
  end

  function automatic logic rb();
    return ($urandom() & 1) != 0;
  endfunction

  // Advance the model across one clock edge with the inputs present at that edge
  task automatic model_edge(input logic s, input logic p, input logic d, input logic r);
    if (!r) begin
      m_st = M_TITLE; m_dest = M_PLAY; m_k = 0; m_init = 0;
      m_prev_s = 1'b1; m_press_s = 1'b0; m_prev_p = 1'b1; m_press_p = 1'b0;
    end else begin
      m_init = 0;
      case (m_st)
        M_TITLE: if (m_press_s) begin m_st = M_CLEAR; m_dest = M_PLAY; m_k = 0; end
        M_CLEAR: begin
          if (m_k == NPIX - 1) begin
            m_st = m_dest; m_init = (m_dest == M_PLAY); m_k = 0;
          end else begin
            m_k++;
          end
        end
        M_PLAY: begin
          if (d) begin m_st = M_CLEAR; m_dest = M_OVER; m_k = 0; end
          else if (m_press_p) m_st = M_PAUSE;
        end
        M_PAUSE: begin
          if (m_press_s) m_st = M_TITLE;
          else if (m_press_p) m_st = M_PLAY;
        end
        M_OVER: if (m_press_s) m_st = M_TITLE;
        default: m_st = M_TITLE;
      endcase
      m_press_s = m_prev_s & ~s; m_prev_s = s;
      m_press_p = m_prev_p & ~p; m_prev_p = p;
    end
  endtask

  task automatic push(input int c);
    exp_t e;
    e.cyc   = c;
    e.flags = {m_st == M_TITLE, m_st == M_PAUSE, m_st == M_OVER, m_st == M_CLEAR,
               m_init && (m_st == M_PLAY), (m_st == M_PLAY) && !m_init};
    e.x     = (m_st == M_CLEAR) ? XW'(m_k % H) : '0;
    e.y     = (m_st == M_CLEAR) ? YW'(m_k / H) : '0;
    exq.push_back(e);
  endtask

  // Drive one cycle of inputs just after the edge and queue the expected outputs
  task automatic slot(input logic s, input logic p, input logic d, input logic r);
    @(posedge clk);
    #2;
    start_n = s; pause_n = p; is_dead = d; rst = r;
    if (!r) begin
      model_edge(s, p, d, 1'b0);
      if (exq.size() > 0 && exq[$].cyc == cnt) void'(exq.pop_back());
      push(cnt);
    end
    model_edge(s, p, d, r);
    push(cnt + 1);
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s bound expired at cycle %0d", nm, cnt);
  endtask

  // Monitor: every cycle pop the entry due now and compare the whole output set
  always @(negedge clk) begin
    while (exq.size() > 0 && exq[0].cyc < cnt) begin
      mon_e = exq.pop_front();
      checks++;
      errors++;
      $display("FAIL stale_expect cycle %0d got no sample want cycle %0d", cnt, mon_e.cyc);
    end
    if (exq.size() > 0 && exq[0].cyc == cnt) begin
      mon_e = exq.pop_front();
      mon_got = {show_title, show_pause, show_game_over, draw_black, game_init, game_en};
      checks++;
      if (mon_got !== mon_e.flags || clr_x !== mon_e.x || clr_y !== mon_e.y) begin
        errors++;
        $display("FAIL outputs cycle %0d got ttl/pau/ovr/blk/ini/en=%b x=%0d y=%0d want %b x=%0d y=%0d",
                 cnt, mon_got, clr_x, clr_y, mon_e.flags, mon_e.x, mon_e.y);
      end
    end
  end

  initial begin
    int n;
    // reset and idle in TITLE
    slot(1, 1, 0, 0);
    slot(1, 1, 0, 0);
    repeat (10) slot(1, 1, 0, 1);

    // start, then reset in the middle of the clear at pixel (80,60)
    slot(0, 1, 0, 1);
    slot(1, 1, 0, 1);
    n = 0;
    while (!(m_st == M_CLEAR && m_k == 80 + 60 * H) && n < 30000) begin
      slot(1, rb(), rb(), 1);
      n++;
    end
    if (n >= 30000) bound_fail("reach_mid_clear");
    repeat (3) slot(1, 1, 0, 0);
    repeat (5) slot(1, 1, 0, 1);

    // held start gives one press; random buttons and is_dead during clear are ignored
    repeat (50) slot(0, rb(), 0, 1);
    n = 0;
    while (m_st != M_PLAY && n < 25000) begin
      if (m_st == M_CLEAR && m_k < NPIX - 10) slot(rb(), rb(), rb(), 1);
      else slot(1, 1, 0, 1);
      n++;
    end
    if (n >= 25000) bound_fail("first_clear_to_play");

    // random pause/resume in PLAY
    repeat (300) slot(1, ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1, 0, 1);
    repeat (3) slot(1, 1, 0, 1);
    n = 0;
    while (m_st != M_PLAY && n < 5) begin
      slot(1, 0, 0, 1);
      repeat (3) slot(1, 1, 0, 1);
      n++;
    end
    if (n >= 5) bound_fail("return_to_play");

    // death together with a pause press, clear to OVER, then back to TITLE
    slot(1, 0, 0, 1);
    slot(1, 0, 1, 1);
    n = 0;
    while (m_st != M_OVER && n < 25000) begin
      if (m_st == M_CLEAR && m_k < NPIX - 10) slot(rb(), rb(), 1, 1);
      else slot(1, 1, 0, 1);
      n++;
    end
    if (n >= 25000) bound_fail("clear_to_over");
    repeat (3) slot(1, 1, 0, 1);
    slot(0, 1, 0, 1);
    repeat (3) slot(1, 1, 0, 1);

    // back into PLAY, pause, then quit with start and pause pressed together
    slot(0, 1, 0, 1);
    n = 0;
    while (m_st != M_PLAY && n < 25000) begin
      slot(1, 1, 0, 1);
      n++;
    end
    if (n >= 25000) bound_fail("second_clear_to_play");
    repeat (4) slot(1, 1, 0, 1);
    slot(1, 0, 0, 1);
    repeat (3) slot(1, 1, 0, 1);
    slot(0, 0, 1, 1);
    slot(1, 1, 1, 1);
    repeat (4) slot(1, 1, 0, 1);

    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries want 0", exq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
